// File: rtl/stopwatch_ctrl_if.sv
// Button, counter and display signals between the stopwatch controller
// and its surroundings (counter datapath, segment decoders, buttons).
interface stopwatch_ctrl_if #(
    parameter int unsigned CNT_W = 6
);
    logic             btn_start;
    logic             btn_lap;
    logic             btn_clr;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] disp_q;
    logic             running;
    logic             lap_active;

    // Environment side: drives buttons and the counter value
    modport master (
        output btn_start, btn_lap, btn_clr, cnt_q,
        input  cnt_en, cnt_clr, disp_q, running, lap_active
    );

    // Controller side
    modport slave (
        input  btn_start, btn_lap, btn_clr, cnt_q,
        output cnt_en, cnt_clr, disp_q, running, lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for the stopwatch seconds counter.
// Decodes button presses into a 4-state FSM, generates the 1 Hz count
// enable from clk_50, issues counter clears and selects the display value.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 6
) (
    input  logic               clk_50,
    input  logic               rst,
    stopwatch_ctrl_if.slave    bus
);
    localparam int unsigned    DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             start_prev;
    logic             lap_prev;
    logic             clr_prev;
    logic             press_start;
    logic             press_lap;
    logic             press_clr;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] lap_reg;
    logic [CNT_W-1:0] lap_reg_next;
    logic [CNT_W-1:0] disp_reg;
    logic             clr_reg;
    logic             counting;

    // Rising-edge press detection on the already-debounced button levels
    always_comb begin
        press_start = bus.btn_start & ~start_prev;
        press_lap   = bus.btn_lap   & ~lap_prev;
        press_clr   = bus.btn_clr   & ~clr_prev;
    end

    // Next-state and lap capture; clr beats start beats lap
    always_comb begin
        next_state   = state;
        lap_reg_next = lap_reg;
        if (press_clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (press_start) next_state = RUN;
                end
                RUN: begin
                    if (press_start) begin
                        next_state = PAUSE;
                    end else if (press_lap) begin
                        next_state   = LAP;
                        lap_reg_next = bus.cnt_q;
                    end
                end
                LAP: begin
                    if (press_start)    next_state = PAUSE;
                    else if (press_lap) next_state = RUN;
                end
                PAUSE: begin
                    if (press_start) next_state = RUN;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Control FSM with registered lap split, display and clear pulse
    always_ff @(posedge clk_50) begin
        if (!rst) begin
            state    <= IDLE;
            lap_reg  <= '0;
            disp_reg <= '0;
            clr_reg  <= 1'b0;
        end else begin
            state    <= next_state;
            lap_reg  <= lap_reg_next;
            // Uses lap_reg_next so the freshly captured split shows on entry to LAP
            disp_reg <= (next_state == LAP) ? lap_reg_next : bus.cnt_q;
            clr_reg  <= press_clr;
        end
    end

    // Button history; preset high so a button held through reset is not a press
    always_ff @(posedge clk_50) begin
        if (!rst) begin
            start_prev <= 1'b1;
            lap_prev   <= 1'b1;
            clr_prev   <= 1'b1;
        end else begin
            start_prev <= bus.btn_start;
            lap_prev   <= bus.btn_lap;
            clr_prev   <= bus.btn_clr;
        end
    end

    assign counting = (state == RUN) || (state == LAP);

    // Tick divider: runs in RUN/LAP, holds in PAUSE to keep the fractional second
    always_ff @(posedge clk_50) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (press_clr || (state == IDLE)) begin
            div_cnt <= '0;
        end else if (counting) begin
            if (div_cnt == DIV_LAST) div_cnt <= '0;
            else                     div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign bus.cnt_en     = counting && (div_cnt == DIV_LAST) && !press_clr;
    assign bus.cnt_clr    = clr_reg;
    assign bus.disp_q     = disp_reg;
    assign bus.running    = counting;
    assign bus.lap_active = (state == LAP);
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4. Each cycle's inputs and
// hand-computed expected outputs are queued; a monitor compares on negedge.
module tb_stopwatch_ctrl;
    logic clk;
    logic rst;

    stopwatch_ctrl_if #(.CNT_W(6)) bus ();

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .CNT_W    (6)
    ) dut (
        .clk_50 (clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic [5:0] disp;
        logic       run;
        logic       lap;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_id   = 0;

    task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s @vec%0d: got %0d want %0d", nm, id, got, want);
        else
            n_pass++;
    endtask

    // One clock cycle: drive inputs for this cycle and queue the outputs expected in it
    task automatic cyc(input logic r, input logic s, input logic l, input logic c, input logic [5:0] q,
                       input logic e_en, input logic e_clr, input logic [5:0] e_disp,
                       input logic e_run, input logic e_lap);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.btn_start = s;
        bus.btn_lap   = l;
        bus.btn_clr   = c;
        bus.cnt_q     = q;
        e.en   = e_en;
        e.clr  = e_clr;
        e.disp = e_disp;
        e.run  = e_run;
        e.lap  = e_lap;
        e.id   = vec_id;
        vec_id++;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle and compares every output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cnt_en",     e.id, {7'd0, bus.cnt_en},     {7'd0, e.en});
                chk("cnt_clr",    e.id, {7'd0, bus.cnt_clr},    {7'd0, e.clr});
                chk("disp_q",     e.id, {2'd0, bus.disp_q},     {2'd0, e.disp});
                chk("running",    e.id, {7'd0, bus.running},    {7'd0, e.run});
                chk("lap_active", e.id, {7'd0, bus.lap_active}, {7'd0, e.lap});
            end
        end
    end

    initial begin
        rst           = 1'b0;
        bus.btn_start = 1'b1;
        bus.btn_lap   = 1'b1;
        bus.btn_clr   = 1'b1;
        bus.cnt_q     = 6'd0;

        // Reset with all buttons held, then keep holding: nothing fires
        for (int i = 0; i < 3; i++)  cyc(0, 1, 1, 1, 0,  0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 1, 0,  0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)  cyc(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Start held 10 cycles: single toggle, pulses at T+4, T+8, T+12
        for (int i = 0; i <= 12; i++)
            cyc(1, i <= 9, 0, 0, 0,  (i >= 1) && (i % 4 == 0), 0, 0, i >= 1, 0);
        cyc(1, 0, 0, 1, 0,  0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Pause/resume keeps the fractional second
        cyc(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0,  1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0,  0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);

        // Lap split freezes 17 while counter advances, second lap releases
        cyc(1, 1, 0, 0, 17,  0, 0, 0,  0, 0);
        cyc(1, 0, 0, 0, 17,  0, 0, 17, 1, 0);
        cyc(1, 0, 1, 0, 17,  0, 0, 17, 1, 0);
        cyc(1, 0, 0, 0, 18,  0, 0, 17, 1, 1);
        cyc(1, 0, 0, 0, 19,  1, 0, 17, 1, 1);
        cyc(1, 0, 0, 0, 20,  0, 0, 17, 1, 1);
        cyc(1, 0, 1, 0, 20,  0, 0, 17, 1, 1);
        cyc(1, 0, 0, 0, 20,  0, 0, 20, 1, 0);
        cyc(1, 0, 0, 0, 20,  1, 0, 20, 1, 0);
        cyc(1, 0, 0, 1, 20,  0, 0, 20, 1, 0);
        cyc(1, 0, 0, 0, 0,   0, 1, 20, 0, 0);
        cyc(1, 0, 0, 0, 0,   0, 0, 0,  0, 0);

        // All three pressed at terminal count: clr wins, pulse suppressed
        cyc(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc(1, 1, 1, 1, 0,  0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0,  1, 0, 0, 1, 0);

        // Clear from LAP, lap ignored in IDLE, clear from PAUSE, lap ignored in PAUSE
        cyc(1, 0, 1, 0, 9,  0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 9,  0, 0, 9, 1, 1);
        cyc(1, 0, 0, 0, 9,  0, 1, 9, 0, 0);
        cyc(1, 0, 1, 0, 0,  0, 0, 9, 0, 0);
        cyc(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 4,  0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 4,  0, 0, 4, 1, 0);
        cyc(1, 0, 1, 0, 4,  0, 0, 4, 0, 0);
        cyc(1, 0, 0, 0, 4,  0, 0, 4, 0, 0);
        cyc(1, 0, 0, 1, 4,  0, 0, 4, 0, 0);
        cyc(1, 0, 0, 0, 0,  0, 1, 4, 0, 0);
        cyc(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        // Reset mid-lap with buttons held: back to reset values, no clr pulse
        cyc(1, 1, 0, 0, 7,  0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 7,  0, 0, 7, 1, 0);
        cyc(1, 0, 1, 0, 7,  0, 0, 7, 1, 0);
        cyc(0, 1, 1, 0, 8,  0, 0, 7, 1, 1);
        cyc(1, 1, 1, 0, 8,  0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 8,  0, 0, 8, 0, 0);
        cyc(1, 0, 0, 0, 8,  0, 0, 8, 0, 0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL drain: got %0d pending want 0", sb.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
